// File: rtl/idma_axis_lane_buffer.sv
// -----------------------------------------------------------------------------
// idma_axis_lane_buffer
//
// Purpose:
//   Per-byte-lane FIFO buffer between a read backend, which delivers
//   read-aligned bytes, and an AXI Stream write backend, which pops bytes
//   lane by lane using its keep mask. Each lane is an independent circular
//   FIFO of Depth entries. A full lane never stalls any other lane.
//
// Parameters:
//   StrbWidth - number of byte lanes (1..64)
//   Depth     - entries per lane FIFO (2..16); any value is allowed
//   byte_t    - per-lane payload type
//
// Ports:
//   clk_i       - sole clock; all state changes on its rising edge
//   rst_i       - asynchronous active-high reset (clears pointers and usage)
//   flush_i     - synchronous clear of all lanes; overrides push and pop
//   in_data_i   - per-lane input bytes
//   in_valid_i  - per-lane push request
//   in_ready_o  - per-lane "can accept" (usage != Depth)
//   out_data_o  - per-lane head byte
//   out_valid_o - per-lane "head valid"
//   out_ready_i - per-lane pop request (write keep mask)
//   empty_o     - every lane holds no stored entries
//
// Configuration:
//   IDMA_AXIS_LANE_BUFFER_FALL_THROUGH_EN - when defined, an empty lane
//   presents in_valid_i/in_data_i combinationally on its outputs. If that
//   lane is also popped in the same cycle, the byte bypasses storage.
//   empty_o always reflects stored entries only.
// -----------------------------------------------------------------------------
module idma_axis_lane_buffer #(
  parameter int unsigned StrbWidth = 16,
  parameter int unsigned Depth     = 3,
  parameter type         byte_t    = logic [7:0]
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  byte_t [StrbWidth-1:0] in_data_i,
  input  logic  [StrbWidth-1:0] in_valid_i,
  output logic  [StrbWidth-1:0] in_ready_o,
  output byte_t [StrbWidth-1:0] out_data_o,
  output logic  [StrbWidth-1:0] out_valid_o,
  input  logic  [StrbWidth-1:0] out_ready_i,
  output logic                  empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam ptr_t LastPtr = ptr_t'(Depth - 1);
  localparam cnt_t FullCnt = cnt_t'(Depth);

  // Explicit wrap so that non-power-of-two depths never need a modulo.
  function automatic ptr_t f_next_ptr(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  logic [StrbWidth-1:0] w_stored;

  for (genvar g = 0; g < StrbWidth; g++) begin : gen_lane
    byte_t r_mem [Depth];
    ptr_t  r_wptr;
    ptr_t  r_rptr;
    cnt_t  r_usage;
    logic  w_has;
    logic  w_push;
    logic  w_pop;

    assign w_has         = (r_usage != '0);
    assign in_ready_o[g] = (r_usage != FullCnt);
    // Pops only ever consume stored entries; a pop with nothing stored is ignored.
    assign w_pop         = out_ready_i[g] & w_has;

`ifdef IDMA_AXIS_LANE_BUFFER_FALL_THROUGH_EN
    logic w_bypass;
    // An empty lane that is popped in the same cycle hands the input byte
    // straight through and does not store it.
    assign w_bypass       = ~w_has & in_valid_i[g] & out_ready_i[g];
    assign w_push         = in_valid_i[g] & in_ready_o[g] & ~w_bypass;
    assign out_valid_o[g] = w_has | (in_valid_i[g] & ~rst_i);
    assign out_data_o[g]  = w_has ? r_mem[r_rptr] : in_data_i[g];
`else
    assign w_push         = in_valid_i[g] & in_ready_o[g];
    assign out_valid_o[g] = w_has;
    assign out_data_o[g]  = r_mem[r_rptr];
`endif

    assign w_stored[g] = w_has;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_usage <= '0;
      end else if (flush_i) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_usage <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= f_next_ptr(r_wptr);
        end
        if (w_pop) begin
          r_rptr <= f_next_ptr(r_rptr);
        end
        if (w_push && !w_pop) begin
          r_usage <= r_usage + cnt_t'(1);
        end else if (w_pop && !w_push) begin
          r_usage <= r_usage - cnt_t'(1);
        end
      end
    end

    // Storage carries no reset; only pointers and usage define its contents.
    always_ff @(posedge clk_i) begin
      if (w_push) begin
        r_mem[r_wptr] <= in_data_i[g];
      end
    end
  end

  assign empty_o = ~|w_stored;

endmodule

// File: tb/tb_idma_axis_lane_buffer.sv
module tb_idma_axis_lane_buffer;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [3:0][7:0] in_data;
  logic [3:0]      in_valid;
  logic [3:0]      out_ready;

  logic [3:0]      ready2;
  logic [3:0][7:0] data2;
  logic [3:0]      valid2;
  logic            empty2;

  logic [3:0]      ready3;
  logic [3:0][7:0] data3;
  logic [3:0]      valid3;
  logic            empty3;

  int checks;
  int failures;

  idma_axis_lane_buffer #(.StrbWidth(4), .Depth(2)) dut2 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (ready2),
    .out_data_o  (data2),
    .out_valid_o (valid2),
    .out_ready_i (out_ready),
    .empty_o     (empty2)
  );

  idma_axis_lane_buffer #(.StrbWidth(4), .Depth(3)) dut3 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (ready3),
    .out_data_o  (data3),
    .out_valid_o (valid3),
    .out_ready_i (out_ready),
    .empty_o     (empty3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = '0;
    out_ready = '0;
    flush     = 1'b0;
    #1;
  endtask

  task automatic do_flush();
    in_valid  = '0;
    out_ready = '0;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    in_data   = '0;
    in_valid  = 4'hF;
    out_ready = '0;
    tick();
    tick();
    checks++;
    if (ready2 !== 4'hF) begin
      failures++;
      $display("FAIL reset_ready2: got %h want f", ready2);
    end
    checks++;
    if (valid2 !== 4'h0 || valid3 !== 4'h0) begin
      failures++;
      $display("FAIL reset_valid: got %h/%h want 0/0", valid2, valid3);
    end
    checks++;
    if (empty2 !== 1'b1 || empty3 !== 1'b1) begin
      failures++;
      $display("FAIL reset_empty: got %b/%b want 1/1", empty2, empty3);
    end
    in_valid = '0;
    rst      = 1'b0;
    #1;
  endtask

  // Runs straight after reset release: first push lands on the first edge.
  task automatic test_all_lanes();
    in_data   = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
    in_valid  = 4'hF;
    out_ready = '0;
    tick();
    in_valid = '0;
    #1;
    checks++;
    if (valid2 !== 4'hF) begin
      failures++;
      $display("FAIL all_valid: got %h want f", valid2);
    end
    checks++;
    if (data2 !== 32'hA4A3A2A1 || data3 !== 32'hA4A3A2A1) begin
      failures++;
      $display("FAIL all_data: got %h/%h want a4a3a2a1", data2, data3);
    end
    checks++;
    if (empty2 !== 1'b0) begin
      failures++;
      $display("FAIL all_empty: got %b want 0", empty2);
    end
    do_flush();
  endtask

  task automatic test_lane_full();
    in_valid  = 4'b0001;
    in_data   = {8'h00, 8'h00, 8'h00, 8'h11};
    tick();
    in_data[0] = 8'h22;
    tick();
    in_valid = '0;
    #1;
    checks++;
    if (ready2 !== 4'b1110) begin
      failures++;
      $display("FAIL full_ready2: got %b want 1110", ready2);
    end
    checks++;
    if (ready3 !== 4'b1111) begin
      failures++;
      $display("FAIL full_ready3: got %b want 1111", ready3);
    end
    // Third push is refused by the Depth=2 lane.
    in_valid   = 4'b0001;
    in_data[0] = 8'h55;
    #1;
    checks++;
    if (ready2[0] !== 1'b0) begin
      failures++;
      $display("FAIL full_ready_hold: got %b want 0", ready2[0]);
    end
    tick();
    in_valid  = '0;
    out_ready = 4'b0001;
    #1;
    checks++;
    if (valid2[0] !== 1'b1 || data2[0] !== 8'h11) begin
      failures++;
      $display("FAIL full_pop1: got v=%b d=%h want v=1 d=11", valid2[0], data2[0]);
    end
    tick();
    checks++;
    if (valid2[0] !== 1'b1 || data2[0] !== 8'h22) begin
      failures++;
      $display("FAIL full_pop2: got v=%b d=%h want v=1 d=22", valid2[0], data2[0]);
    end
    tick();
    out_ready = '0;
    #1;
    checks++;
    if (valid2[0] !== 1'b0 || empty2 !== 1'b1) begin
      failures++;
      $display("FAIL full_drained: got v=%b e=%b want v=0 e=1", valid2[0], empty2);
    end
    checks++;
    if (valid3[0] !== 1'b1 || data3[0] !== 8'h55) begin
      failures++;
      $display("FAIL full_deep_kept: got v=%b d=%h want v=1 d=55", valid3[0], data3[0]);
    end
    do_flush();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_head;
    in_valid   = 4'b0010;
    in_data[1] = 8'h70;
    tick();
    exp_head = 8'h70;
    for (int k = 0; k < 5; k++) begin
      in_valid   = 4'b0010;
      out_ready  = 4'b0010;
      in_data[1] = 8'h77 + 8'(k);
      #1;
      checks++;
      if (valid2[1] !== 1'b1 || data2[1] !== exp_head || ready2[1] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_step%0d: got v=%b d=%h r=%b want v=1 d=%h r=1",
                 k, valid2[1], data2[1], ready2[1], exp_head);
      end
      tick();
      exp_head = 8'h77 + 8'(k);
    end
    idle_inputs();
    checks++;
    if (valid2[1] !== 1'b1 || data2[1] !== 8'h7B || ready2[1] !== 1'b1 || ready3[1] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_final: got v=%b d=%h r=%b/%b want v=1 d=7b r=1/1",
               valid2[1], data2[1], ready2[1], ready3[1]);
    end
    do_flush();
  endtask

  task automatic test_interleave();
    logic [9:0] push_pat;
    logic [9:0] pop_pat;
    logic [7:0] q[$];
    logic [7:0] next_byte;
    // Bit i is cycle i: 7 pushes, 7 pops, usage peaks at 2.
    push_pat  = 10'b0011110111;
    pop_pat   = 10'b1111011100;
    next_byte = 8'hC0;
    for (int c = 0; c < 10; c++) begin
      in_valid   = {1'b0, push_pat[c], 2'b00};
      out_ready  = {1'b0, pop_pat[c], 2'b00};
      in_data[2] = next_byte;
      #1;
      if (pop_pat[c]) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL interleave_model%0d: got empty model want data", c);
        end else if (valid3[2] !== 1'b1 || data3[2] !== q[0]) begin
          failures++;
          $display("FAIL interleave_pop%0d: got v=%b d=%h want v=1 d=%h",
                   c, valid3[2], data3[2], q[0]);
        end
      end
      tick();
      if (pop_pat[c] && q.size() > 0) void'(q.pop_front());
      if (push_pat[c]) begin
        q.push_back(next_byte);
        next_byte = next_byte + 8'h01;
      end
    end
    idle_inputs();
    checks++;
    if (valid3[2] !== 1'b0 || empty3 !== 1'b1) begin
      failures++;
      $display("FAIL interleave_end: got v=%b e=%b want v=0 e=1", valid3[2], empty3);
    end
    do_flush();
  endtask

  task automatic test_flush();
    in_valid = 4'hF;
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    in_valid = 4'hF;
    flush    = 1'b1;
    tick();
    in_valid = '0;
    flush    = 1'b0;
    #1;
    checks++;
    if (valid2 !== 4'h0 || valid3 !== 4'h0) begin
      failures++;
      $display("FAIL flush_valid: got %h/%h want 0/0", valid2, valid3);
    end
    checks++;
    if (empty2 !== 1'b1 || empty3 !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty: got %b/%b want 1/1", empty2, empty3);
    end
    checks++;
    if (ready2 !== 4'hF || ready3 !== 4'hF) begin
      failures++;
      $display("FAIL flush_ready: got %h/%h want f/f", ready2, ready3);
    end
    in_valid   = 4'b0001;
    in_data[0] = 8'h5A;
    tick();
    in_valid = '0;
    #1;
    checks++;
    if (valid2[0] !== 1'b1 || data2[0] !== 8'h5A) begin
      failures++;
      $display("FAIL flush_refill: got v=%b d=%h want v=1 d=5a", valid2[0], data2[0]);
    end
    do_flush();
  endtask

  task automatic test_fall_through();
    in_valid   = 4'b1000;
    out_ready  = 4'b1000;
    in_data[3] = 8'h3C;
    #1;
`ifdef IDMA_AXIS_LANE_BUFFER_FALL_THROUGH_EN
    checks++;
    if (valid2[3] !== 1'b1 || data2[3] !== 8'h3C) begin
      failures++;
      $display("FAIL ft_same_cycle: got v=%b d=%h want v=1 d=3c", valid2[3], data2[3]);
    end
    checks++;
    if (empty2 !== 1'b1) begin
      failures++;
      $display("FAIL ft_empty: got %b want 1", empty2);
    end
    tick();
    idle_inputs();
    checks++;
    if (valid2[3] !== 1'b0 || empty2 !== 1'b1) begin
      failures++;
      $display("FAIL ft_not_stored: got v=%b e=%b want v=0 e=1", valid2[3], empty2);
    end
`else
    checks++;
    if (valid2[3] !== 1'b0) begin
      failures++;
      $display("FAIL nft_same_cycle: got v=%b want v=0", valid2[3]);
    end
    tick();
    idle_inputs();
    checks++;
    if (valid2[3] !== 1'b1 || data2[3] !== 8'h3C || empty2 !== 1'b0) begin
      failures++;
      $display("FAIL nft_stored: got v=%b d=%h e=%b want v=1 d=3c e=0",
               valid2[3], data2[3], empty2);
    end
`endif
    do_flush();
  endtask

  task automatic test_async_reset();
    in_valid = 4'hF;
    in_data  = {8'hD4, 8'hD3, 8'hD2, 8'hD1};
    tick();
    in_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (valid2 !== 4'h0 || empty2 !== 1'b1 || ready2 !== 4'hF) begin
      failures++;
      $display("FAIL async_reset: got v=%h e=%b r=%h want v=0 e=1 r=f", valid2, empty2, ready2);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (valid3 !== 4'h0 || empty3 !== 1'b1) begin
      failures++;
      $display("FAIL async_release: got v=%h e=%b want v=0 e=1", valid3, empty3);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_all_lanes();
    test_lane_full();
    test_back_to_back();
    test_interleave();
    test_flush();
    test_fall_through();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
